msg_schedule: RTL and testbench
===============================

Name: msg_schedule

Overview:
SHA-256 message-schedule stage. It sits directly upstream of the 32-bit `msg` input of the round/compression unit.
- Accepts one 512-bit block as 16 big-endian 32-bit words over a valid/ready handshake.
- Streams the 64 schedule words W0..W63, one per output handshake.
- A 16-word sliding window holds the state; the block does no padding (done upstream).

Parameters:
NUM_ROUNDS, 64, number of schedule words emitted per block; legal range 16..64.

Ports:
clk       input   1   clock, all state on rising edge
reset     input   1   asynchronous, active-high reset
in_valid  input   1   in_word is valid
in_ready  output  1   block accepts a word (high only in LOAD)
in_word   input   32  message word, word 0 of the block first
out_valid output  1   out_word/out_idx valid (high only in STREAM)
out_ready input   1   consumer accepts the current word
out_word  output  32  current schedule word W[out_idx]
out_idx   output  6   round index t of out_word, 0..NUM_ROUNDS-1

Behaviour:
- Interface (already decided): one clock `clk`; `reset` is asynchronous and active-high.
- Reset values: state=LOAD, load count=0, out_idx=0, window cleared to 0, so out_word=0. in_ready=1, out_valid=0.
- Handshake: a transfer occurs on a rising edge with valid&&ready.
  - in_ready and out_valid are decoded from state only; they have no combinational path from in_valid or out_ready.
- State LOAD:
  - Each input transfer writes in_word into window[load_cnt] and increments load_cnt.
  - On the 16th transfer (load_cnt==15), load_cnt returns to 0 and state goes to STREAM.
  - out_valid rises the cycle after the 16th accept, with out_word=W0 and out_idx=0.
- State STREAM:
  - out_word = window[0].
  - On each output transfer: window[i] <= window[i+1] for i=0..14, and window[15] <= sigma1(window[14]) + window[9] + sigma0(window[1]) + window[0]. The sum is mod 2^32 and carries are discarded.
  - On the same transfer, out_idx increments.
  - sigma0(x) = ROTR7(x) ^ ROTR18(x) ^ SHR3(x).
  - sigma1(x) = ROTR17(x) ^ ROTR19(x) ^ SHR10(x).
- Last word:
  - The transfer with out_idx==NUM_ROUNDS-1 sets out_idx to 0 and state to LOAD.
  - in_ready rises the next cycle. Blocks never overlap.
- Backpressure: while out_valid && !out_ready, out_word and out_idx hold stable.
- Ignored inputs: in_valid in STREAM has no effect; out_ready in LOAD has no effect.
- Reset mid-LOAD or mid-STREAM:
  - The partial block is discarded and all reset values apply immediately.
  - No word is emitted for the discarded block.
- Throughput: at best 16 cycles to load plus NUM_ROUNDS cycles to stream per block.

Optional Feature:
Macro: MSG_SCHEDULE_LAST_EN.
- Defined: adds output port `out_last` (1 bit).
  - out_last = out_valid && (out_idx==NUM_ROUNDS-1).
  - Reset value 0.
  - Marks the final schedule word of a block for the downstream round unit.
- Undefined: the port is absent and all other behaviour is identical.

Decomposition:
- Package msg_schedule_pkg holds:
  - WORD_W=32, BLOCK_WORDS=16, IDX_W=6.
  - The state enum {LOAD, STREAM}.
  - Rotate/shift amounts: 7/18/3 and 17/19/10.
- One combinational sub-module, msg_schedule_expand:
  - Inputs: w0, w1, w9, w14.
  - Output: the next window word (sigma0, sigma1 and the 4-input adder).
- Window registers, counters and FSM stay in msg_schedule.

Test Plan:
1. Padded "abc" block (0x61626380, fourteen 0x00000000, 0x00000018), out_ready=1 → W0=0x61626380 at idx 0; W15=0x00000018; W16=0x61626380; W17=0x000F0000. Exactly 64 words are emitted, then in_ready returns.
2. Backpressure: hold out_ready=0 for 5 cycles at idx 20 → out_word and out_idx stable throughout; sequence resumes at idx 21 with no word lost or repeated.
3. in_valid=1 with junk words during STREAM → no effect on outputs; in_ready stays 0 until the idx-63 transfer.
4. Assert reset at idx 30, then load a new block → out_valid drops, idx=0, in_ready=1 immediately. The new block's W0..W63 match a golden model.
5. Back-to-back random blocks with random in_valid/out_ready gaps, checked against a software SHA-256 schedule model → all words match; out_idx wraps 63→0 per block.
6. With MSG_SCHEDULE_LAST_EN defined and NUM_ROUNDS=20 → out_last is high only with idx 19; 20 words are emitted per block.

Source files
------------

// File: rtl/msg_schedule_pkg.sv
// Shared widths, FSM state type and sigma rotate/shift amounts for the SHA-256 message schedule.
package msg_schedule_pkg;
  localparam int WORD_W      = 32;
  localparam int BLOCK_WORDS = 16;
  localparam int IDX_W       = 6;

  localparam int S0_ROT_A = 7;
  localparam int S0_ROT_B = 18;
  localparam int S0_SHR   = 3;
  localparam int S1_ROT_A = 17;
  localparam int S1_ROT_B = 19;
  localparam int S1_SHR   = 10;

  typedef enum logic {
    LOAD   = 1'b0,
    STREAM = 1'b1
  } state_e;
endpackage

// File: rtl/msg_schedule_expand.sv
// Combinational schedule expansion: next window word from window taps 0, 1, 9 and 14.
module msg_schedule_expand
  import msg_schedule_pkg::*;
(
  input  logic [WORD_W-1:0] w0_i,
  input  logic [WORD_W-1:0] w1_i,
  input  logic [WORD_W-1:0] w9_i,
  input  logic [WORD_W-1:0] w14_i,
  output logic [WORD_W-1:0] next_o
);

  function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x, input int n);
    return (x >> n) | (x << (WORD_W - n));
  endfunction

  function automatic logic [WORD_W-1:0] sigma0(input logic [WORD_W-1:0] x);
    return rotr(x, S0_ROT_A) ^ rotr(x, S0_ROT_B) ^ (x >> S0_SHR);
  endfunction

  function automatic logic [WORD_W-1:0] sigma1(input logic [WORD_W-1:0] x);
    return rotr(x, S1_ROT_A) ^ rotr(x, S1_ROT_B) ^ (x >> S1_SHR);
  endfunction

  // Modulo-2^32 sum: carries out of bit 31 are dropped by the result width.
  assign next_o = sigma1(w14_i) + w9_i + sigma0(w1_i) + w0_i;

endmodule

// File: rtl/msg_schedule.sv
// SHA-256 message schedule: loads 16 words, then streams W0..W(NUM_ROUNDS-1) from a sliding window.
// Optional MSG_SCHEDULE_LAST_EN adds out_last, flagging the final word of each block.
module msg_schedule
  import msg_schedule_pkg::*;
#(
  parameter int NUM_ROUNDS = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_word,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_word,
  output logic [IDX_W-1:0]  out_idx
`ifdef MSG_SCHEDULE_LAST_EN
  ,
  output logic              out_last
`endif
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ROUNDS - 1);

  state_e            state_q;
  logic [3:0]        load_cnt_q;
  logic [IDX_W-1:0]  idx_q;
  logic [WORD_W-1:0] win_q [BLOCK_WORDS];
  logic [WORD_W-1:0] win_next_d;

  msg_schedule_expand u_expand (
    .w0_i   (win_q[0]),
    .w1_i   (win_q[1]),
    .w9_i   (win_q[9]),
    .w14_i  (win_q[14]),
    .next_o (win_next_d)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= LOAD;
      load_cnt_q <= '0;
      idx_q      <= '0;
      for (int i = 0; i < BLOCK_WORDS; i++) win_q[i] <= '0;
    end else if (state_q == LOAD) begin
      if (in_valid) begin
        win_q[load_cnt_q] <= in_word;
        load_cnt_q        <= 4'(load_cnt_q + 4'd1);
        if (load_cnt_q == 4'd15) state_q <= STREAM;
      end
    end else begin
      // Each accepted output slides the window one word and appends W[t+16].
      if (out_ready) begin
        for (int i = 0; i < BLOCK_WORDS - 1; i++) win_q[i] <= win_q[i+1];
        win_q[BLOCK_WORDS-1] <= win_next_d;
        if (idx_q == LAST_IDX) begin
          idx_q   <= '0;
          state_q <= LOAD;
        end else begin
          idx_q <= IDX_W'(idx_q + 1'b1);
        end
      end
    end
  end

  assign in_ready  = (state_q == LOAD);
  assign out_valid = (state_q == STREAM);
  assign out_word  = win_q[0];
  assign out_idx   = idx_q;
`ifdef MSG_SCHEDULE_LAST_EN
  assign out_last  = (state_q == STREAM) && (idx_q == LAST_IDX);
`endif

endmodule

// File: tb/tb_msg_schedule.sv
// Scoreboard bench for msg_schedule: reference schedule words queued at block load, compared at each output transfer.
module tb_msg_schedule;

`ifdef MSG_SCHEDULE_LAST_EN
  localparam int NR = 20;
`else
  localparam int NR = 64;
`endif
  localparam int BP_IDX  = (NR > 25) ? 20 : 10;
  localparam int RST_IDX = (NR > 35) ? 30 : 12;
  localparam int LIMIT   = 2000;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_word;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_word;
  logic [5:0]  out_idx;
`ifdef MSG_SCHEDULE_LAST_EN
  logic        out_last;
`endif

  logic fixed_ready;
  logic rnd_ready;
  logic rand_mode;
  logic abc_mode;
  assign out_ready = rand_mode ? rnd_ready : fixed_ready;

  msg_schedule #(.NUM_ROUNDS(NR)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_word   (in_word),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_word  (out_word),
    .out_idx   (out_idx)
`ifdef MSG_SCHEDULE_LAST_EN
    ,
    .out_last  (out_last)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] w;
    logic [5:0]  idx;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_chk  = 0;
  int   n_pass = 0;
  int   n_out  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  // Reference: textbook recurrence W[t] = s1(W[t-2]) + W[t-7] + s0(W[t-15]) + W[t-16].
  task automatic push_block(input logic [31:0] blk [16]);
    logic [31:0] w [64];
    exp_t e;
    for (int t = 0; t < 16; t++) w[t] = blk[t];
    for (int t = 16; t < 64; t++) w[t] = ssig1(w[t-2]) + w[t-7] + ssig0(w[t-15]) + w[t-16];
    for (int t = 0; t < NR; t++) begin
      e.w   = w[t];
      e.idx = 6'(t);
      sb_q.push_back(e);
    end
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    int cnt;
    in_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    in_valid = 1'b1;
    in_word  = w;
    cnt = 0;
    while (!in_ready && cnt < LIMIT) begin @(posedge clk); #1; cnt++; end
    if (cnt >= LIMIT) chk("in_ready_timeout", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_block(input logic [31:0] blk [16], input logic gaps);
    push_block(blk);
    for (int i = 0; i < 16; i++) send_word(blk[i], gaps ? int'($urandom_range(0, 2)) : 0);
  endtask

  task automatic drain(input string tag);
    int cnt = 0;
    while (sb_q.size() != 0 && cnt < LIMIT) begin @(posedge clk); #1; cnt++; end
    if (cnt >= LIMIT) chk({tag, "_drain_timeout"}, 32'(sb_q.size()), 32'd0);
    chk({tag, "_in_ready_back"}, 32'(in_ready), 32'd1);
    chk({tag, "_out_valid_low"}, 32'(out_valid), 32'd0);
  endtask

  task automatic wait_idx(input int idx);
    int cnt = 0;
    while (!(out_valid && out_idx == 6'(idx)) && cnt < LIMIT) begin
      @(posedge clk); #1;
      in_word = $urandom;
      cnt++;
    end
    if (cnt >= LIMIT) chk("wait_idx_timeout", 32'(out_idx), 32'(idx));
  endtask

  function automatic void rand_block(output logic [31:0] blk [16]);
    for (int i = 0; i < 16; i++) blk[i] = $urandom;
  endfunction

  // Output monitor: sampled on the falling edge, a transfer happens at the next rising edge.
  always @(negedge clk) begin
    if (!reset && out_valid) begin
`ifdef MSG_SCHEDULE_LAST_EN
      chk("out_last", 32'(out_last), 32'(out_idx == 6'(NR - 1)));
`endif
      if (out_ready) begin
        if (sb_q.size() == 0) begin
          chk("extra_word", out_word, 32'hxxxx_xxxx);
        end else begin
          mon_e = sb_q.pop_front();
          chk("word", out_word, mon_e.w);
          chk("idx", 32'(out_idx), 32'(mon_e.idx));
          n_out++;
          if (abc_mode) begin
            if (out_idx == 6'd0)  chk("abc_w0", out_word, 32'h6162_6380);
            if (out_idx == 6'd15) chk("abc_w15", out_word, 32'h0000_0018);
            if (out_idx == 6'd16) chk("abc_w16", out_word, 32'h6162_6380);
            if (out_idx == 6'd17) chk("abc_w17", out_word, 32'h000F_0000);
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      rnd_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] blk [16];
    int start_out;

    reset = 1'b1; in_valid = 1'b0; in_word = '0;
    fixed_ready = 1'b1; rnd_ready = 1'b1; rand_mode = 1'b0; abc_mode = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_idx", 32'(out_idx), 32'd0);
    chk("rst_out_word", out_word, 32'd0);
`ifdef MSG_SCHEDULE_LAST_EN
    chk("rst_out_last", 32'(out_last), 32'd0);
`endif
    reset = 1'b0;
    @(posedge clk); #1;

    // Padded "abc" block.
    for (int i = 0; i < 16; i++) blk[i] = 32'h0;
    blk[0] = 32'h6162_6380;
    blk[15] = 32'h0000_0018;
    abc_mode = 1'b1;
    start_out = n_out;
    send_block(blk, 1'b0);
    chk("first_out_valid", 32'(out_valid), 32'd1);
    chk("first_out_idx", 32'(out_idx), 32'd0);
    drain("abc");
    chk("abc_word_count", 32'(n_out - start_out), 32'(NR));
    abc_mode = 1'b0;

    // Backpressure plus junk input words during streaming.
    rand_block(blk);
    send_block(blk, 1'b0);
    in_valid = 1'b1;
    wait_idx(BP_IDX);
    fixed_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      in_word = $urandom;
      chk("bp_word", out_word, sb_q[0].w);
      chk("bp_idx", 32'(out_idx), 32'(BP_IDX));
      chk("junk_in_ready", 32'(in_ready), 32'd0);
    end
    fixed_ready = 1'b1;
    wait_idx(NR - 3);
    chk("junk_in_ready_late", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    drain("bp");

    // Reset in the middle of streaming, then a fresh block.
    rand_block(blk);
    send_block(blk, 1'b0);
    wait_idx(RST_IDX);
    reset = 1'b1;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_out_idx", 32'(out_idx), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    sb_q.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    rand_block(blk);
    send_block(blk, 1'b0);
    drain("post_rst");

    // Back-to-back random blocks with random gaps and backpressure.
    rand_mode = 1'b1;
    start_out = n_out;
    for (int b = 0; b < 4; b++) begin
      rand_block(blk);
      send_block(blk, 1'b1);
    end
    drain("rand");
    chk("rand_word_count", 32'(n_out - start_out), 32'(4 * NR));
    rand_mode = 1'b0;

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
